lcd_msg_formatter: RTL and testbench



---
 rtl/lcd_msg_formatter.sv | 115 +++++++++++
 tb/tb_lcd_msg_formatter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_msg_formatter.sv
// Formats a 32-char LCD message: fixed line 1, line 2 = prefix + 5-digit decimal of value_i.
// Latency: start accepted at E0, mensaje_o[39:0] and done_o update at E17 (18-cycle throughput).
// Backpressure: none; start_i is ignored while busy_o=1 and is neither queued nor re-sampled.
module lcd_msg_formatter #(
    parameter logic [127:0] LINE1_TEXT   = "VALOR DECIMAL   ",
    parameter logic [87:0]  LINE2_PREFIX = "VALOR:     ",
    parameter bit           LZ_BLANK     = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [15:0]  value_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [255:0] mensaje_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Digit field shown after reset: a lone "0" in the units column, or all zeros.
    localparam logic [39:0] DIGITS_RST = LZ_BLANK ? 40'h20_20_20_20_30 : 40'h30_30_30_30_30;

    state_t      state_q;
    logic [15:0] shift_q;
    logic [19:0] bcd_q;
    logic [4:0]  cnt_q;
    logic [39:0] digits_q;
    logic        busy_q;
    logic        done_q;

    logic [19:0] bcd_adj;
    logic [39:0] digits_d;

    // Turns the five BCD nibbles into ASCII, blanking leading zeros except the units digit.
    function automatic logic [39:0] format_digits(input logic [19:0] bcd);
        logic [39:0] r;
        logic        lead;
        r    = '0;
        lead = 1'b1;
        for (int k = 4; k >= 0; k--) begin
            if (bcd[4*k +: 4] != 4'd0) begin
                lead = 1'b0;
            end
            if (LZ_BLANK && lead && (k != 0)) begin
                r[8*k +: 8] = 8'h20;
            end else begin
                r[8*k +: 8] = {4'h3, bcd[4*k +: 4]};
            end
        end
        return r;
    endfunction

    // Double-dabble correction: any nibble of 5 or more gets +3 before the next shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < 5; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
        digits_d = format_digits(bcd_q);
    end

    // Conversion FSM: capture in IDLE, 16 shift cycles, then one write cycle with done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            digits_q <= DIGITS_RST;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        shift_q <= value_i;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_q, shift_q} <= {bcd_adj[18:0], shift_q, 1'b0};
                    cnt_q            <= cnt_q + 5'd1;
                    if (cnt_q == 5'd15) begin
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    digits_q <= digits_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign mensaje_o = {LINE1_TEXT, LINE2_PREFIX, digits_q};

endmodule

// File: tb/tb_lcd_msg_formatter.sv
// Bench for lcd_msg_formatter: two instances (leading-zero blanking on and off) share stimulus.
// Expected digit fields come from a decimal arithmetic model of the formatting rules.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_lcd_msg_formatter;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [15:0]  value;
    logic         busy1, done1, busy0, done0;
    logic [255:0] msg1, msg0;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] L1 = "VALOR DECIMAL   ";
    localparam logic [87:0]  P2 = "VALOR:     ";

    logic [39:0] prev1, prev0;

    always #5 clk = ~clk;

    lcd_msg_formatter #(.LZ_BLANK(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .value_i(value),
        .busy_o(busy1), .done_o(done1), .mensaje_o(msg1)
    );

    lcd_msg_formatter #(.LZ_BLANK(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .value_i(value),
        .busy_o(busy0), .done_o(done0), .mensaje_o(msg0)
    );

    // Reference: digit k is (v / 10^k) % 10; blanked when v < 10^k (k >= 1) with blanking on.
    function automatic logic [39:0] ref_fmt(input int v, input bit blank);
        logic [39:0] r;
        int          pw;
        r  = '0;
        pw = 1;
        for (int k = 0; k < 5; k++) begin
            if (blank && k > 0 && v < pw) r[8*k +: 8] = 8'h20;
            else                          r[8*k +: 8] = 8'h30 + 8'((v / pw) % 10);
            pw = pw * 10;
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full conversion of v with cycle-by-cycle checks from E0 to E18.
    task automatic run_conv(input logic [15:0] v, input bit scramble, input string name);
        int busy_cnt;
        logic [39:0] e1, e0;
        e1 = ref_fmt(int'(v), 1'b1);
        e0 = ref_fmt(int'(v), 1'b0);
        start = 1'b1;
        value = v;
        tick;                                   // E0
        start = 1'b0;
        if (scramble) value = 16'($urandom);
        checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            failures++;
            $display("FAIL %s_e0 busy=%b done=%b required busy=1 done=0", name, busy1, done1);
        end
        busy_cnt = 1;
        for (int i = 1; i <= 16; i++) begin
            tick;
            if (busy1 === 1'b1) busy_cnt++;
            checks++;
            if (done1 !== 1'b0 || {msg1[39:0], msg0[39:0]} !== {prev1, prev0}) begin
                failures++;
                $display("FAIL %s_hold cyc=%0d done=%b dig=%h/%h required done=0 dig=%h/%h",
                         name, i, done1, msg1[39:0], msg0[39:0], prev1, prev0);
            end
        end
        checks++;
        if (busy_cnt != 17) begin
            failures++;
            $display("FAIL %s_busy_len got=%0d required=17", name, busy_cnt);
        end
        tick;                                   // E17
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || done0 !== 1'b1 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL %s_e17_flags busy=%b done=%b busy0=%b done0=%b required done=1 busy=0",
                     name, busy1, done1, busy0, done0);
        end
        checks++;
        if (msg1 !== {L1, P2, e1}) begin
            failures++;
            $display("FAIL %s_msg got=%h required=%h", name, msg1, {L1, P2, e1});
        end
        checks++;
        if (msg0 !== {L1, P2, e0}) begin
            failures++;
            $display("FAIL %s_msg_nolz got=%h required=%h", name, msg0[39:0], e0);
        end
        prev1 = e1;
        prev0 = e0;
        tick;                                   // E18
        checks++;
        if (done1 !== 1'b0 || msg1[39:0] !== prev1) begin
            failures++;
            $display("FAIL %s_e18 done=%b dig=%h required done=0 dig=%h", name, done1, msg1[39:0], prev1);
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        value = 16'd0;
        tick;
        tick;
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags busy=%b done=%b required 0 0", busy1, done1);
        end
        checks++;
        if (msg1 !== {L1, P2, 40'h2020202030}) begin
            failures++;
            $display("FAIL reset_msg got=%h required=%h", msg1, {L1, P2, 40'h2020202030});
        end
        checks++;
        if (msg0 !== {L1, P2, 40'h3030303030}) begin
            failures++;
            $display("FAIL reset_msg_nolz got=%h required=%h", msg0, {L1, P2, 40'h3030303030});
        end
        rst   = 1'b0;
        prev1 = ref_fmt(0, 1'b1);
        prev0 = ref_fmt(0, 1'b0);
        tick;
    endtask

    task automatic test_single;
        run_conv(16'd12345, 1'b0, "single");
        checks++;
        if (msg1[39:0] !== 40'h3132333435) begin
            failures++;
            $display("FAIL single_const got=%h required=3132333435", msg1[39:0]);
        end
    endtask

    task automatic test_sequence;
        run_conv(16'd65535, 1'b0, "seq_max");
        checks++;
        if (msg1[39:0] !== 40'h3635353335) begin
            failures++;
            $display("FAIL seq_max_const got=%h required=3635353335", msg1[39:0]);
        end
        run_conv(16'd0, 1'b0, "seq_zero");
        checks++;
        if (msg1[39:0] !== 40'h2020202030) begin
            failures++;
            $display("FAIL seq_zero_const got=%h required=2020202030", msg1[39:0]);
        end
        run_conv(16'd7, 1'b0, "seq_seven");
        checks++;
        if (msg1[39:0] !== 40'h2020202037 || msg0[39:0] !== 40'h3030303037) begin
            failures++;
            $display("FAIL seq_seven_const got=%h/%h required=2020202037/3030303037",
                     msg1[39:0], msg0[39:0]);
        end
    endtask

    task automatic test_ignore_busy_start;
        int ndone;
        int done_cyc;
        logic [39:0] dig_at_done;
        ndone       = 0;
        done_cyc    = -1;
        dig_at_done = '0;
        start = 1'b1;
        value = 16'd100;
        tick;                                   // E0
        start = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            tick;
            if (done1 === 1'b1) begin
                ndone++;
                done_cyc    = c;
                dig_at_done = msg1[39:0];
            end
            if (c == 4) begin
                start = 1'b1;                   // sampled at E5 while busy
                value = 16'd999;
            end
            if (c == 5) start = 1'b0;
        end
        checks++;
        if (ndone != 1 || done_cyc != 17) begin
            failures++;
            $display("FAIL ignore_done count=%0d at=%0d required count=1 at=17", ndone, done_cyc);
        end
        checks++;
        if (dig_at_done !== 40'h2020313030) begin
            failures++;
            $display("FAIL ignore_msg got=%h required=2020313030", dig_at_done);
        end
        prev1 = ref_fmt(100, 1'b1);
        prev0 = ref_fmt(100, 1'b0);
    endtask

    task automatic test_reset_mid;
        int ndone;
        start = 1'b1;
        value = 16'd54321;
        tick;                                   // E0
        start = 1'b0;
        repeat (7) tick;                        // E7
        rst   = 1'b1;
        start = 1'b1;                           // simultaneous start must lose to reset
        value = 16'd77;
        tick;                                   // E8
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_flags busy=%b done=%b required 0 0", busy1, done1);
        end
        checks++;
        if (msg1 !== {L1, P2, 40'h2020202030} || msg0[39:0] !== 40'h3030303030) begin
            failures++;
            $display("FAIL rstmid_msg got=%h required=%h", msg1, {L1, P2, 40'h2020202030});
        end
        rst   = 1'b0;
        start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            tick;
            if (done1 === 1'b1 || busy1 === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL rstmid_quiet active_cycles=%0d required=0", ndone);
        end
        prev1 = ref_fmt(0, 1'b1);
        prev0 = ref_fmt(0, 1'b0);
        run_conv(16'd42, 1'b0, "after_rst");
        checks++;
        if (msg1[39:0] !== 40'h2020203432) begin
            failures++;
            $display("FAIL after_rst_const got=%h required=2020203432", msg1[39:0]);
        end
    endtask

    task automatic test_back_to_back;
        int pulses[$];
        int nbad;
        nbad  = 0;
        start = 1'b1;
        value = 16'd321;
        tick;                                   // E0
        for (int c = 1; c <= 53; c++) begin
            tick;
            if (done1 === 1'b1) begin
                pulses.push_back(c);
                if (msg1[39:0] !== 40'h2020333231) nbad++;
            end
            if (c == 53) start = 1'b0;
        end
        checks++;
        if (pulses.size() != 3 || pulses[0] != 17 || pulses[1] != 35 || pulses[2] != 53) begin
            failures++;
            $display("FAIL b2b_pulses n=%0d first=%0d required n=3 at 17,35,53",
                     pulses.size(), (pulses.size() > 0) ? pulses[0] : -1);
        end
        checks++;
        if (nbad != 0) begin
            failures++;
            $display("FAIL b2b_msg bad_pulses=%0d required=0 (digits 2020333231)", nbad);
        end
        tick;
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle busy=%b done=%b required 0 0", busy1, done1);
        end
        prev1 = ref_fmt(321, 1'b1);
        prev0 = ref_fmt(321, 1'b0);
    endtask

    task automatic test_random;
        logic [15:0] v;
        int          sel;
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       v = 16'($urandom_range(0, 9));
                1:       v = 16'($urandom_range(10, 999));
                default: v = 16'($urandom);
            endcase
            repeat ($urandom_range(0, 3)) tick;
            run_conv(v, 1'b1, "random");
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        value = 16'd0;
        test_reset;
        test_single;
        test_sequence;
        test_ignore_busy_start;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
